lms_adapt_seq: RTL
==================

Name: lms_adapt_seq

Overview:
- Parametrised successor to the fixed 9-tap, 16-bit LMS adaptive filter.
- Implements an N-tap LMS filter with one time-multiplexed multiplier. It runs at full clock rate, paced by a sample-valid strobe instead of a divided clock.
- Per accepted sample it runs filter MAC, then error, then optional coefficient update, and reports busy/overrun status.
- Coefficients can be read back for debug and verification.

Parameters:
- TAPS, 9, number of filter taps (≥2)
- DW, 16, data/reference/error width, signed Q1.(DW-1)
- CW, 16, coefficient width, signed Q1.(CW-1)
- MU_SHIFT, 4, step size mu = 2^-MU_SHIFT (0..DW)

Ports:
- clk_i, in, 1, system clock
- rst_i, in, 1, synchronous active-high reset
- sample_valid_i, in, 1, one-cycle strobe; data_in/data_ref are valid this cycle
- data_in, in, DW, signed input sample
- data_ref, in, DW, signed reference (desired) sample
- adapt_en_i, in, 1, sampled at accept; 1 = run coefficient update
- coef_clr_i, in, 1, zero all coefficients (honoured only in IDLE)
- coef_rd_addr_i, in, clog2(TAPS), coefficient readback index
- coef_rd_o, out, CW, coefficient[coef_rd_addr_i], combinational read
- data_o, out, DW, filter output y
- error_o, out, DW, e = ref − y
- valid_o, out, 1, one-cycle pulse; data_o/error_o newly updated
- busy_o, out, 1, high whenever state ≠ IDLE
- overrun_o, out, 1, sticky: a sample was dropped

Behaviour:
- Reset (rst_i=1 at clk_i edge):
  - state=IDLE; delay line, coefficients, accumulator, data_o, error_o all 0.
  - valid_o=0, busy_o=0, overrun_o=0.
  - Reset has priority in every state, including mid-MAC and mid-update.
- States: IDLE, FILT, ERR, UPD.
- IDLE:
  - sample_valid_i=1: shift data_in into x[0] (x[k]←x[k−1]); latch data_ref and adapt_en_i; clear accumulator; tap index=0; go to FILT. This is cycle 0.
  - Else if coef_clr_i=1: all coefficients ← 0 next cycle.
  - sample_valid_i has priority over coef_clr_i.
- FILT, cycles 1..TAPS: acc += x[i]*c[i], one tap per cycle, i=0..TAPS−1.
  - Accumulator width is DW+CW+clog2(TAPS), so it never overflows.
  - After tap TAPS−1, go to ERR.
- ERR, cycle TAPS+1:
  - y = sat_DW(acc >>> (CW−1)).
  - e = sat_DW(ref − y), computed at DW+1 bits before saturation.
  - Register data_o←y and error_o←e.
  - valid_o=1 during cycle TAPS+2, exactly one cycle.
  - Next state is UPD if the latched adapt_en=1, else IDLE.
- UPD, cycles TAPS+2..2·TAPS+1, one tap per cycle:
  - c[i] ← sat_CW(c[i] + ((e*x[i]) >>> (DW−1+MU_SHIFT))).
  - The shift is arithmetic, truncating toward −inf.
  - After the last tap, go to IDLE.
- Next sample can be accepted at cycle 2·TAPS+2 with adapt, or TAPS+2 without.
- Saturation: clamp to [−2^(W−1), 2^(W−1)−1]; wrap-around is never permitted.
- Overrun: sample_valid_i while busy_o=1 drops the sample; state, delay line and coefficients are unaffected.
  - overrun_o=1 from the next cycle; clears only on reset or on coef_clr_i in IDLE.
- coef_clr_i outside IDLE is ignored.
- adapt_en_i changes mid-operation have no effect until the next accept.
- data_o/error_o hold their values between updates.

Test Plan:
- Reset → all outputs 0, coef_rd_o=0 for every address; assert rst_i during UPD → coefficients 0 and busy_o=0 on the next cycle.
- TAPS=9, adapt_en=0, coefs 0, data_in=16384, data_ref=8192 at cycle 0 → valid_o at cycle 11, data_o=0, error_o=8192, busy_o low at cycle 11, coefs stay 0.
- adapt_en=1, MU_SHIFT=4, data_in=16384, data_ref=16384 from reset → error_o=16384, c[0]=512, c[1..8]=0, busy_o low at cycle 20.
- MU_SHIFT=0, adapt_en=1:
  - Sample 1: x=32767, ref=32767 → c[0]=32766.
  - Sample 2: x=32767, ref=−32768 → data_o=32765, error_o=−32768 (saturated, not wrapped).
- sample_valid_i pulsed at cycle 5 of a busy sequence → sample dropped, outputs match the no-overrun run, overrun_o=1 sticky; coef_clr_i in IDLE → coefs 0, overrun_o=0.
- Back-to-back samples, one per 2·TAPS+2 cycles, 200 random samples → matches a bit-exact reference model: every error_o and, via readback, every coefficient.

Source files
------------

// File: rtl/lms_adapt_seq.sv
// N-tap LMS adaptive filter built around one shared multiplier.
// Each accepted sample runs MAC (TAPS cycles), error (1 cycle), then an optional update (TAPS cycles).
module lms_adapt_seq #(
    parameter int TAPS     = 9,
    parameter int DW       = 16,
    parameter int CW       = 16,
    parameter int MU_SHIFT = 4,
    localparam int AW      = $clog2(TAPS)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          sample_valid_i,
    input  logic [DW-1:0] data_in,
    input  logic [DW-1:0] data_ref,
    input  logic          adapt_en_i,
    input  logic          coef_clr_i,
    input  logic [AW-1:0] coef_rd_addr_i,
    output logic [CW-1:0] coef_rd_o,
    output logic [DW-1:0] data_o,
    output logic [DW-1:0] error_o,
    output logic          valid_o,
    output logic          busy_o,
    output logic          overrun_o
);

    localparam int ACCW = DW + CW + AW;
    localparam int MW   = (CW > DW) ? CW : DW;
    localparam int PW   = DW + MW;
    localparam int UW   = PW + 1;
    localparam logic [AW-1:0] LAST = AW'(TAPS - 1);
    localparam logic signed [ACCW-1:0] Y_MAX = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACCW-1:0] Y_MIN = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};
    localparam logic signed [UW-1:0]   C_MAX = {{(UW-CW+1){1'b0}}, {(CW-1){1'b1}}};
    localparam logic signed [UW-1:0]   C_MIN = {{(UW-CW+1){1'b1}}, {(CW-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, FILT, ERR, UPD} state_t;

    state_t                 state_q, state_d;
    logic signed [DW-1:0]   x_q [TAPS];
    logic signed [CW-1:0]   c_q [TAPS];
    logic signed [ACCW-1:0] acc_q;
    logic [AW-1:0]          idx_q;
    logic signed [DW-1:0]   ref_q;
    logic                   adapt_q;
    logic signed [DW-1:0]   data_q;
    logic signed [DW-1:0]   error_q;
    logic                   valid_q;
    logic                   overrun_q;

    // The single multiplier: x[i]*c[i] while filtering, e*x[i] while updating.
    logic signed [DW-1:0]   mul_a;
    logic signed [MW-1:0]   mul_b;
    logic signed [PW-1:0]   prod;
    assign mul_a = x_q[idx_q];
    assign mul_b = (state_q == UPD) ? MW'(error_q) : MW'(c_q[idx_q]);
    assign prod  = mul_a * mul_b;

    logic signed [ACCW-1:0] acc_shift;
    logic signed [DW-1:0]   y_sat;
    logic signed [DW:0]     e_wide;
    logic signed [DW-1:0]   e_sat;
    logic signed [PW-1:0]   delta;
    logic signed [UW-1:0]   c_sum;
    logic signed [CW-1:0]   c_sat;

    assign acc_shift = acc_q >>> (CW - 1);
    assign e_wide    = {ref_q[DW-1], ref_q} - {y_sat[DW-1], y_sat};
    assign delta     = prod >>> (DW - 1 + MU_SHIFT);
    assign c_sum     = UW'(c_q[idx_q]) + UW'(delta);

    always_comb begin
        y_sat = acc_shift[DW-1:0];
        if (acc_shift > Y_MAX)      y_sat = Y_MAX[DW-1:0];
        else if (acc_shift < Y_MIN) y_sat = Y_MIN[DW-1:0];
        e_sat = e_wide[DW-1:0];
        if (e_wide[DW] != e_wide[DW-1]) e_sat = e_wide[DW] ? Y_MIN[DW-1:0] : Y_MAX[DW-1:0];
        c_sat = c_sum[CW-1:0];
        if (c_sum > C_MAX)      c_sat = C_MAX[CW-1:0];
        else if (c_sum < C_MIN) c_sat = C_MIN[CW-1:0];
    end

    // sample_valid_i is a strobe with no back-pressure: it is taken only in IDLE;
    // a strobe while busy is dropped and latched into overrun_o.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (sample_valid_i) state_d = FILT;
            FILT: if (idx_q == LAST) state_d = ERR;
            ERR:  state_d = adapt_q ? UPD : IDLE;
            UPD:  if (idx_q == LAST) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            for (int k = 0; k < TAPS; k++) begin
                x_q[k] <= '0;
                c_q[k] <= '0;
            end
            acc_q     <= '0;
            idx_q     <= '0;
            ref_q     <= '0;
            adapt_q   <= 1'b0;
            data_q    <= '0;
            error_q   <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (sample_valid_i) begin
                        for (int k = TAPS - 1; k > 0; k--) x_q[k] <= x_q[k-1];
                        x_q[0]  <= data_in;
                        ref_q   <= data_ref;
                        adapt_q <= adapt_en_i;
                        acc_q   <= '0;
                        idx_q   <= '0;
                    end else if (coef_clr_i) begin
                        for (int k = 0; k < TAPS; k++) c_q[k] <= '0;
                        overrun_q <= 1'b0;
                    end
                end
                FILT: begin
                    acc_q <= acc_q + ACCW'(prod);
                    idx_q <= (idx_q == LAST) ? '0 : idx_q + 1'b1;
                end
                ERR: begin
                    data_q  <= y_sat;
                    error_q <= e_sat;
                    valid_q <= 1'b1;
                    idx_q   <= '0;
                end
                UPD: begin
                    c_q[idx_q] <= c_sat;
                    idx_q      <= (idx_q == LAST) ? '0 : idx_q + 1'b1;
                end
                default: ;
            endcase
            if (sample_valid_i && state_q != IDLE) overrun_q <= 1'b1;
        end
    end

    assign coef_rd_o = (coef_rd_addr_i <= LAST) ? c_q[coef_rd_addr_i] : '0;
    assign data_o    = data_q;
    assign error_o   = error_q;
    assign valid_o   = valid_q;
    assign busy_o    = (state_q != IDLE);
    assign overrun_o = overrun_q;

endmodule
